// File: rtl/fft_result_streamer.sv
// fft_result_streamer: reads N_POINTS = 2^ADDR_W result words from the FFT BRAM
// and streams them on a valid/ready port with last/done signalling.
// A 2-entry buffer plus a bypass of the BRAM read data gives one word per
// cycle under continuous ready and holds at most two words under backpressure.
// Optional macro FFT_BIT_REVERSE_EN: read address is the bit-reverse of the
// index, so a bit-reversed BRAM leaves in natural order. Timing is unchanged.
module fft_result_streamer #(
    parameter int ADDR_W = 9,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              fft_ready_i,
    output logic              rd_en_o,
    output logic [ADDR_W-1:0] rd_addr_o,
    input  logic [DATA_W-1:0] rd_data_i,
    output logic [DATA_W-1:0] m_data_o,
    output logic              m_valid_o,
    input  logic              m_ready_i,
    output logic              m_last_o,
    output logic              busy_o,
    output logic              done_o
);
    localparam int CNT_W = ADDR_W + 1;
    localparam logic [CNT_W-1:0] LAST_IDX = {1'b0, {ADDR_W{1'b1}}};

    typedef enum logic [1:0] {IDLE, STREAM, DRAIN, DONE} state_t;

    state_t            state, state_nxt;
    logic [CNT_W-1:0]  rd_idx, out_idx;
    logic              inflight;
    logic [DATA_W-1:0] buf_mem [2];
    logic              wr_ptr, rd_ptr;
    logic [1:0]        count;
    logic              start, xfer, bypass, push, pop;

    // Output side: buffered head first, otherwise the word arriving from BRAM
    assign m_valid_o = (count != 2'd0) || inflight;
    assign m_data_o  = (count != 2'd0) ? buf_mem[rd_ptr] :
                       (inflight ? rd_data_i : '0);
    assign xfer      = m_valid_o && m_ready_i;
    assign bypass    = (count == 2'd0) && inflight && m_ready_i;
    assign push      = inflight && !bypass;
    assign pop       = xfer && (count != 2'd0);
    assign m_last_o  = m_valid_o && (out_idx == LAST_IDX);

`ifdef FFT_BIT_REVERSE_EN
    // Bit-reversed read address
    always_comb begin
        rd_addr_o = '0;
        for (int i = 0; i < ADDR_W; i++) rd_addr_o[i] = rd_idx[ADDR_W-1-i];
    end
`else
    assign rd_addr_o = rd_idx[ADDR_W-1:0];
`endif

    // State register
    always_ff @(posedge clk) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    // Next state and control outputs; a read issues only while buffered plus
    // in-flight words stay below two, so the buffer can never overflow
    always_comb begin
        state_nxt = state;
        rd_en_o   = 1'b0;
        busy_o    = 1'b0;
        done_o    = 1'b0;
        start     = 1'b0;
        case (state)
            IDLE: begin
                if (fft_ready_i) begin
                    start     = 1'b1;
                    state_nxt = STREAM;
                end
            end
            STREAM: begin
                busy_o = 1'b1;
                if ((count + {1'b0, inflight}) < 2'd2) begin
                    rd_en_o = 1'b1;
                    if (rd_idx == LAST_IDX) state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                busy_o = 1'b1;
                // all reads issued: the last transfer leaves nothing behind
                if (xfer && m_last_o) state_nxt = DONE;
            end
            DONE: begin
                done_o    = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Counters, in-flight flag and 2-entry buffer
    always_ff @(posedge clk) begin
        if (!rst) begin
            rd_idx     <= '0;
            out_idx    <= '0;
            inflight   <= 1'b0;
            wr_ptr     <= 1'b0;
            rd_ptr     <= 1'b0;
            count      <= 2'd0;
            buf_mem[0] <= '0;
            buf_mem[1] <= '0;
        end else begin
            inflight <= rd_en_o;
            if (start) begin
                rd_idx  <= '0;
                out_idx <= '0;
                wr_ptr  <= 1'b0;
                rd_ptr  <= 1'b0;
                count   <= 2'd0;
            end else begin
                if (rd_en_o) rd_idx <= rd_idx + 1'b1;
                if (xfer)    out_idx <= out_idx + 1'b1;
                if (push) begin
                    buf_mem[wr_ptr] <= rd_data_i;
                    wr_ptr          <= ~wr_ptr;
                end
                if (pop) rd_ptr <= ~rd_ptr;
                count <= count + {1'b0, push} - {1'b0, pop};
            end
        end
    end

endmodule

// File: doc/fft_result_streamer.md
# fft_result_streamer

Downstream stage of the radix-2 FFT core: once the control unit raises `fft_ready_o`, this block reads all N result words out of the shared BRAM and streams them on a valid/ready output port. It absorbs the 1-cycle BRAM read latency with a 2-entry buffer, so it sustains one word per cycle under continuous `m_ready_i` and loses nothing under backpressure. It marks the last word and signals completion so the control unit can return to idle.

## Interface
- `ADDR_W`, 9, BRAM address width; N_POINTS = 2^ADDR_W.
- `DATA_W`, 32, result word width (packed {re[15:0], im[15:0]}; contents not interpreted).
- `clk`  in  1  clock; all logic is on the rising edge.
- `rst`  in  1  synchronous, active-low reset.
- `fft_ready_i`  in  1  results valid in BRAM; sampled only in IDLE.
- `rd_en_o`  out  1  BRAM read enable.
- `rd_addr_o`  out  ADDR_W  BRAM read address.
- `rd_data_i`  in  DATA_W  BRAM read data, valid the cycle after `rd_en_o`.
- `m_data_o`  out  DATA_W  output word.
- `m_valid_o`  out  1  output word valid.
- `m_ready_i`  in  1  sink accepts the word; a transfer occurs when valid && ready.
- `m_last_o`  out  1  high with the word of index N_POINTS-1.
- `busy_o`  out  1  high in STREAM and DRAIN.
- `done_o`  out  1  one-cycle pulse after the last transfer.

## Operation
- States: IDLE, STREAM, DRAIN, DONE.
- IDLE: if `fft_ready_i` = 1, clear the index counter `rd_idx` and the buffer, then go to STREAM.
- STREAM: assert `rd_en_o` when occupancy + in-flight reads < 2. Each issued read increments `rd_idx`. When the read at index N_POINTS-1 issues, go to DRAIN.
- DRAIN: issue no reads. When the buffer is empty, nothing is in flight, and the last transfer has completed, go to DONE.
- DONE: assert `done_o` for one cycle, then go to IDLE.
- Buffer: 2-entry FIFO. Write on the cycle after `rd_en_o`; pop on transfer. Simultaneous write and pop leaves occupancy unchanged. The head drives `m_data_o`.
- Output index: `out_idx` counts transfers. `m_last_o` = `m_valid_o` && (`out_idx` == N_POINTS-1).
- `rd_addr_o` = f(`rd_idx`), with f defined under Configuration. Counters are ADDR_W+1 bits wide so that index N_POINTS is representable and no wrap occurs before termination.
- `fft_ready_i` is ignored outside IDLE. If it is still high in the cycle after DONE, a new pass starts.
- `m_data_o` stays stable while `m_valid_o` && !`m_ready_i`.

## Timing
- Reset values: all outputs 0, state IDLE, counters and buffer cleared.
- Reset asserted mid-pass: at the next edge, outputs go to 0, the in-flight read is discarded, and the state returns to IDLE.
- `fft_ready_i` sampled at edge T0 → state is STREAM at T0+1 with `rd_en_o` = 1, `rd_addr_o` = f(0) → `m_valid_o` = 1 at T0+2.
- With `m_ready_i` held high: one transfer per cycle. Last transfer at T0+N_POINTS+1. `done_o` at T0+N_POINTS+2. IDLE at T0+N_POINTS+3.
- When `m_ready_i` drops, reads stop within one cycle and the buffer holds at most 2 words. No overflow and no duplicate or missing words.
- N_POINTS = 2^ADDR_W is assumed. No non-power-of-two support.

## Configuration
- `FFT_BIT_REVERSE_EN`
  - Defined: f(i) = bit-reverse of i[ADDR_W-1:0]. Outputs leave in natural frequency order from a BRAM stored in bit-reversed order.
  - Undefined: f(i) = i[ADDR_W-1:0], so words leave in BRAM order.
  - All timing is identical in both builds.

## Test plan
- Reset mid-stream: assert `rst` = 0 after 3 transfers → at the next edge all outputs are 0 and the state is IDLE. A new `fft_ready_i` pulse then streams from index 0.
- Continuous stream, ADDR_W = 2, BRAM[i] = 0x100+i, macro undefined, `m_ready_i` = 1 → outputs 0x100, 0x101, 0x102, 0x103 on consecutive cycles starting T0+2. `m_last_o` is high only with 0x103, and `done_o` pulses at T0+6.
- Same setup with `FFT_BIT_REVERSE_EN` defined → read addresses are 0, 2, 1, 3 and outputs are 0x100, 0x102, 0x101, 0x103.
- Backpressure, ADDR_W = 3, `m_ready_i` toggled 1,0,0,1,0,1… → exactly 8 transfers of 0x100..0x107 in order. `m_data_o` is stable while stalled, and `rd_en_o` is never high when occupancy + in-flight = 2.
- `fft_ready_i` held high throughout → back-to-back passes. `done_o` pulses once per pass, and the next pass's `rd_en_o` is high 2 cycles after `done_o`.
